// File: rtl/decode_pkg.sv
// Shared constants for the MIPS ID stage: opcodes, ALUOp encodings and
// control bundle layouts reused by decode, execute and control logic.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam int WB_CTL_W = 2;
  localparam int M_CTL_W  = 3;
  localparam int EX_CTL_W = 4;

  typedef struct packed {
    logic       regdst;
    logic [1:0] aluop;
    logic       alusrc;
  } ex_ctl_t;

  typedef struct packed {
    logic branch;
    logic memread;
    logic memwrite;
  } m_ctl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctl_t;

  function automatic logic [31:0] sign_extend(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32x32 register file: two asynchronous read ports with write-through bypass,
// one synchronous write port, register 0 hardwired to zero.
module regfile
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] regs_q [32];
  logic        wr_en_s;

  assign wr_en_s = we_i && (wa_i != 5'd0);

  // Register array storage; entry 0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (wr_en_s) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Read ports: r0 is zero, a same-cycle write to the read index wins.
  always_comb begin
    rd1_o = 32'd0;
    rd2_o = 32'd0;
    if (ra1_i == 5'd0) begin
      rd1_o = 32'd0;
    end else if (wr_en_s && (wa_i == ra1_i)) begin
      rd1_o = wd_i;
    end else begin
      rd1_o = regs_q[ra1_i];
    end
    if (ra2_i == 5'd0) begin
      rd2_o = 32'd0;
    end else if (wr_en_s && (wa_i == ra2_i)) begin
      rd2_o = wd_i;
    end else begin
      rd2_o = regs_q[ra2_i];
    end
  end

endmodule

// File: rtl/decode.sv
// MIPS instruction decode stage: control decode, sign extension, register
// file read and the ID/EX pipeline latch.
module decode
  import decode_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         if_instr,
  input  logic [31:0]         if_npc,
  input  logic                wb_reg_write,
  input  logic [4:0]          wb_write_reg,
  input  logic [31:0]         wb_write_data,
  output logic [WB_CTL_W-1:0] wb_ctlout,
  output logic [M_CTL_W-1:0]  m_ctlout,
  output logic [EX_CTL_W-1:0] ex_ctlout,
  output logic [31:0]         npcout,
  output logic [31:0]         rdata1out,
  output logic [31:0]         rdata2out,
  output logic [31:0]         s_extendout,
  output logic [4:0]          instr_2016out,
  output logic [4:0]          instr_1511out
);

  logic [5:0]  opcode_s;
  logic [31:0] rdata1_s;
  logic [31:0] rdata2_s;
  ex_ctl_t     ex_d, ex_q;
  m_ctl_t      m_d, m_q;
  wb_ctl_t     wb_d, wb_q;
  logic [31:0] npc_q, rdata1_q, rdata2_q, sext_q;
  logic [4:0]  rt_q, rd_q;

  assign opcode_s = if_instr[31:26];

  regfile u_regfile (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (if_instr[25:21]),
    .ra2_i (if_instr[20:16]),
    .we_i  (wb_reg_write),
    .wa_i  (wb_write_reg),
    .wd_i  (wb_write_data),
    .rd1_o (rdata1_s),
    .rd2_o (rdata2_s)
  );

  // Opcode to control bundles; the all-zero word is a NOP, not an R-type.
  always_comb begin
    ex_d = '0;
    m_d  = '0;
    wb_d = '0;
    if (if_instr == 32'd0) begin
      ex_d = '0;
    end else begin
      case (opcode_s)
        OP_RTYPE: begin
          ex_d = '{regdst: 1'b1, aluop: ALUOP_FUNCT, alusrc: 1'b0};
          wb_d = '{regwrite: 1'b1, memtoreg: 1'b0};
        end
        OP_LW: begin
          ex_d = '{regdst: 1'b0, aluop: ALUOP_ADD, alusrc: 1'b1};
          m_d  = '{branch: 1'b0, memread: 1'b1, memwrite: 1'b0};
          wb_d = '{regwrite: 1'b1, memtoreg: 1'b1};
        end
        OP_SW: begin
          ex_d = '{regdst: 1'b0, aluop: ALUOP_ADD, alusrc: 1'b1};
          m_d  = '{branch: 1'b0, memread: 1'b0, memwrite: 1'b1};
        end
        OP_BEQ: begin
          ex_d = '{regdst: 1'b0, aluop: ALUOP_SUB, alusrc: 1'b0};
          m_d  = '{branch: 1'b1, memread: 1'b0, memwrite: 1'b0};
        end
        default: begin
          ex_d = '0;
        end
      endcase
    end
  end

  // ID/EX latch, free-running with no stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q     <= '0;
      m_q      <= '0;
      wb_q     <= '0;
      npc_q    <= 32'd0;
      rdata1_q <= 32'd0;
      rdata2_q <= 32'd0;
      sext_q   <= 32'd0;
      rt_q     <= 5'd0;
      rd_q     <= 5'd0;
    end else begin
      ex_q     <= ex_d;
      m_q      <= m_d;
      wb_q     <= wb_d;
      npc_q    <= if_npc;
      rdata1_q <= rdata1_s;
      rdata2_q <= rdata2_s;
      sext_q   <= sign_extend(if_instr[15:0]);
      rt_q     <= if_instr[20:16];
      rd_q     <= if_instr[15:11];
    end
  end

  assign ex_ctlout     = ex_q;
  assign m_ctlout      = m_q;
  assign wb_ctlout     = wb_q;
  assign npcout        = npc_q;
  assign rdata1out     = rdata1_q;
  assign rdata2out     = rdata2_q;
  assign s_extendout   = sext_q;
  assign instr_2016out = rt_q;
  assign instr_1511out = rd_q;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for the ID stage: directed cases plus random
// instructions checked against a register-array reference model.
module tb_decode;

  logic        clk;
  logic        rst;
  logic [31:0] if_instr;
  logic [31:0] if_npc;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic [3:0]  ex_ctlout;
  logic [31:0] npcout, rdata1out, rdata2out, s_extendout;
  logic [4:0]  instr_2016out, instr_1511out;

  int errors = 0;
  int checks = 0;
  logic [31:0] mregs [32];

  decode dut (
    .clk           (clk),
    .rst           (rst),
    .if_instr      (if_instr),
    .if_npc        (if_npc),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .wb_write_data (wb_write_data),
    .wb_ctlout     (wb_ctlout),
    .m_ctlout      (m_ctlout),
    .ex_ctlout     (ex_ctlout),
    .npcout        (npcout),
    .rdata1out     (rdata1out),
    .rdata2out     (rdata2out),
    .s_extendout   (s_extendout),
    .instr_2016out (instr_2016out),
    .instr_1511out (instr_1511out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Control table as {ex[3:0], m[2:0], wb[1:0]}.
  function automatic logic [8:0] ref_ctl(input logic [31:0] ins);
    if (ins == 32'd0) return 9'd0;
    case (ins[31:26])
      6'h00:   return 9'b1100_000_10;
      6'h23:   return 9'b0001_010_11;
      6'h2B:   return 9'b0001_001_00;
      6'h04:   return 9'b0010_100_00;
      default: return 9'd0;
    endcase
  endfunction

  // Drive one cycle at a negedge, then check the latched result a cycle later.
  task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] npc,
                      input logic we, input logic [4:0] wr, input logic [31:0] wd);
    logic [8:0]  ctl;
    logic [31:0] e1, e2;
    if_instr = ins; if_npc = npc;
    wb_reg_write = we; wb_write_reg = wr; wb_write_data = wd;
    if (we && wr != 5'd0) mregs[wr] = wd;
    e1 = mregs[ins[25:21]];
    e2 = mregs[ins[20:16]];
    ctl = ref_ctl(ins);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".ex"},   {28'd0, ex_ctlout}, {28'd0, ctl[8:5]});
    chk({tag, ".m"},    {29'd0, m_ctlout},  {29'd0, ctl[4:2]});
    chk({tag, ".wb"},   {30'd0, wb_ctlout}, {30'd0, ctl[1:0]});
    chk({tag, ".npc"},  npcout, npc);
    chk({tag, ".rd1"},  rdata1out, e1);
    chk({tag, ".rd2"},  rdata2out, e2);
    chk({tag, ".sext"}, s_extendout, {{16{ins[15]}}, ins[15:0]});
    chk({tag, ".rt"},   {27'd0, instr_2016out}, {27'd0, ins[20:16]});
    chk({tag, ".rdf"},  {27'd0, instr_1511out}, {27'd0, ins[15:11]});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ctl"}, {23'd0, ex_ctlout, m_ctlout, wb_ctlout}, 32'd0);
    chk({tag, ".npc"}, npcout, 32'd0);
    chk({tag, ".rd1"}, rdata1out, 32'd0);
    chk({tag, ".rd2"}, rdata2out, 32'd0);
    chk({tag, ".sext"}, s_extendout, 32'd0);
    chk({tag, ".fld"}, {22'd0, instr_2016out, instr_1511out}, 32'd0);
  endtask

  initial begin
    logic [31:0] ins;
    logic [5:0]  op;
    rst = 1'b1;
    if_instr = 32'd0; if_npc = 32'd0;
    wb_reg_write = 1'b0; wb_write_reg = 5'd0; wb_write_data = 32'd0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset0");
    rst = 1'b0;

    step("wr_r1", 32'd0, 32'd1, 1'b1, 5'd1, 32'd5);
    step("wr_r2", 32'd0, 32'd2, 1'b1, 5'd2, 32'd7);
    step("add",   32'h00221820, 32'd4, 1'b0, 5'd0, 32'd0);
    chk("add.rd1_lit", rdata1out, 32'd5);
    chk("add.ex_lit", {28'd0, ex_ctlout}, {28'd0, 4'b1100});
    step("lw",    32'h8C22FFFC, 32'd5, 1'b0, 5'd0, 32'd0);
    chk("lw.sext_lit", s_extendout, 32'hFFFFFFFC);
    step("sw",    32'hAC220008, 32'd6, 1'b0, 5'd0, 32'd0);
    step("beq",   32'h10220003, 32'd7, 1'b0, 5'd0, 32'd0);
    chk("beq.m_lit", {29'd0, m_ctlout}, {29'd0, 3'b100});
    step("bypass", 32'h00800000, 32'd8, 1'b1, 5'd4, 32'hDEADBEEF);
    chk("bypass.lit", rdata1out, 32'hDEADBEEF);
    step("wr_r0", 32'd0, 32'd9, 1'b1, 5'd0, 32'd9);
    step("rd_r0", 32'h00000000 | {6'h23, 5'd0, 5'd0, 16'h0010}, 32'd10, 1'b1, 5'd0, 32'd9);
    chk("rd_r0.lit", rdata1out, 32'd0);
    step("nop",   32'h00000000, 32'd11, 1'b0, 5'd0, 32'd0);
    step("unk",   32'hFC228001, 32'd12, 1'b0, 5'd0, 32'd0);
    chk("unk.sext_lit", s_extendout, 32'hFFFF8001);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        4: op = 6'h3F;
        default: op = 6'($urandom);
      endcase
      ins = {op, 26'($urandom)};
      if ($urandom_range(0, 15) == 0) ins = 32'd0;
      step("rand", ins, $urandom, 1'($urandom), 5'($urandom), $urandom);
    end

    // Asynchronous reset mid-cycle with non-zero inputs.
    if_instr = 32'h8C22FFFC; if_npc = 32'h1234;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("reset_async");
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step("post_rst", {6'h23, 5'(i), 5'(31 - i), 16'h0}, 32'(i), 1'b0, 5'd0, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
